// File: rtl/mem_pkg.sv
// Shared memory-stage types and helpers: access FSM states, default base
// address, index widths and the byte-address to word-index mapping.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int WIDX_W  = 30;
  localparam int CNT_W   = 4;

  // Byte offset from base turned into a word index; wraps for addresses below base.
  function automatic logic [WIDX_W-1:0] word_index(input logic [31:0] address,
                                                   input logic [31:0] base);
    return WIDX_W'((address - base) >> 5'd2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that stalls at zero; the zero flag paces SRAM
// wait states.
module sram_wait_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sram_responder.sv
// Behavioural SRAM responder for the cache request interface: fixed
// wait-state latency, 64-bit block reads, 32-bit word writes.
module sram_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 131072,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [63:0] readData,
  output logic        ready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_t state_r, state_next_s;
  logic [31:0] addr_r, wdata_r;
  logic        op_wr_r;
  logic        latch_s, cnt_load_s, cnt_en_s, cnt_zero_s, commit_s;

  logic [WIDX_W-1:0] idx_s, blk_lo_s, blk_hi_s;
  logic              above_s, wr_ok_s, lo_ok_s, hi_ok_s;
  logic [31:0]       lo_word_s, hi_word_s;
  logic [31:0]       mem_r [DEPTH_WORDS];

  sram_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load_s),
    .load_value (WAIT_LOAD),
    .enable     (cnt_en_s),
    .zero       (cnt_zero_s)
  );

  // Next-state logic; the commit strobe marks the DONE entry edge.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rdEn || wrEn) begin
          latch_s      = 1'b1;
          cnt_load_s   = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_zero_s) begin
          commit_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          cnt_en_s     = 1'b1;
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture; wrEn wins when both requests are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      op_wr_r <= 1'b0;
    end else if (latch_s) begin
      addr_r  <= address;
      wdata_r <= writeData;
      op_wr_r <= wrEn;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      op_wr_r <= op_wr_r;
    end
  end

  // Range checks: each half of a block is checked on its own.
  always_comb begin
    above_s   = (addr_r >= BASE_ADDR);
    idx_s     = word_index(addr_r, BASE_ADDR);
    blk_lo_s  = {idx_s[WIDX_W-1:1], 1'b0};
    blk_hi_s  = {idx_s[WIDX_W-1:1], 1'b1};
    wr_ok_s   = above_s && ({2'b00, idx_s} < DEPTH_LIM);
    lo_ok_s   = above_s && ({2'b00, blk_lo_s} < DEPTH_LIM);
    hi_ok_s   = above_s && ({2'b00, blk_hi_s} < DEPTH_LIM);
    lo_word_s = lo_ok_s ? mem_r[blk_lo_s[IDX_W-1:0]] : 32'd0;
    hi_word_s = hi_ok_s ? mem_r[blk_hi_s[IDX_W-1:0]] : 32'd0;
  end

  // Storage is never cleared; reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit_s && op_wr_r && wr_ok_s) begin
      mem_r[idx_s[IDX_W-1:0]] <= wdata_r;
    end
  end

  // Read data register, only a completed read changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData <= 64'd0;
    end else if (commit_s && !op_wr_r) begin
      readData <= {hi_word_s, lo_word_s};
    end else begin
      readData <= readData;
    end
  end

  assign ready = (state_r == DONE) || ((state_r == IDLE) && !rdEn && !wrEn);

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: a default instance plus a small,
// single-wait-state instance for upper-range and back-to-back traffic.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd1, wr1, rdy1, rd2, wr2, rdy2;
  logic [31:0] addr1, wdat1, addr2, wdat2;
  logic [63:0] rdat1, rdat2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  logic [31:0] model1 [int unsigned];
  logic [31:0] model2 [int unsigned];
  logic [63:0] last1, last2;

  always #5 clk = ~clk;

  sram_responder dut1 (
    .clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1), .address(addr1),
    .writeData(wdat1), .readData(rdat1), .ready(rdy1)
  );

  sram_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .rdEn(rd2), .wrEn(wr2), .address(addr2),
    .writeData(wdat2), .readData(rdat2), .ready(rdy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned depth_of(input int sel);
    return (sel != 0) ? 32'd16 : 32'd131072;
  endfunction

  function automatic logic [31:0] model_word(input int sel, input int unsigned w);
    if (sel != 0) return model2.exists(w) ? model2[w] : 32'd0;
    else          return model1.exists(w) ? model1[w] : 32'd0;
  endfunction

  function automatic logic [63:0] model_block(input int sel, input logic [31:0] a);
    int unsigned idx, blk;
    logic [31:0] lo, hi;
    if (a < 32'd1024) return 64'd0;
    idx = (a - 32'd1024) >> 2;
    blk = idx & ~32'd1;
    lo  = (blk < depth_of(sel)) ? model_word(sel, blk) : 32'd0;
    hi  = (blk + 1 < depth_of(sel)) ? model_word(sel, blk + 1) : 32'd0;
    return {hi, lo};
  endfunction

  task automatic model_write(input int sel, input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    if (a >= 32'd1024) begin
      idx = (a - 32'd1024) >> 2;
      if (idx < depth_of(sel)) begin
        if (sel != 0) model2[idx] = d;
        else          model1[idx] = d;
      end
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      rd2 = r; wr2 = w; addr2 = a; wdat2 = d;
    end else begin
      rd1 = r; wr1 = w; addr1 = a; wdat1 = d;
    end
  endtask

  task automatic access(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    int lows;
    logic rdy, is_rd;
    logic [63:0] exp;
    is_rd = r && !w;
    if (is_rd) exp_q.push_back(model_block(sel, a));
    else       model_write(sel, a, d);
    @(posedge clk); #1;
    drive(sel, r, w, a, d);
    lows = 0;
    rdy  = 1'b0;
    while (!rdy && lows < 40) begin
      @(negedge clk);
      rdy = (sel != 0) ? rdy2 : rdy1;
      if (!rdy) lows++;
    end
    check($sformatf("latency dut%0d addr %h", sel + 1, a), 64'(lows), (sel != 0) ? 64'd2 : 64'd6);
    if (is_rd) begin
      exp = exp_q.pop_front();
      check($sformatf("read dut%0d addr %h", sel + 1, a), (sel != 0) ? rdat2 : rdat1, exp);
      if (sel != 0) last2 = exp; else last1 = exp;
    end else begin
      check($sformatf("readData held dut%0d addr %h", sel + 1, a),
            (sel != 0) ? rdat2 : rdat1, (sel != 0) ? last2 : last1);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    last1 = 64'd0;
    last2 = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready dut1", 64'(rdy1), 64'd1);
    check("reset readData dut1", rdat1, 64'd0);
    check("reset ready dut2", 64'(rdy2), 64'd1);
    check("reset readData dut2", rdat2, 64'd0);

    // write then read, both halves of the block
    access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'd1028, 32'h12345678);
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0);
    check("block literal", rdat1, 64'h12345678_DEADBEEF);
    access(0, 1'b1, 1'b0, 32'd1028, 32'd0);

    // both requests high behaves as a write
    access(0, 1'b0, 1'b1, 32'd1036, 32'h0BADF00D);
    access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5);
    access(0, 1'b1, 1'b0, 32'd1032, 32'd0);
    check("both-high low word", {32'd0, rdat1[31:0]}, 64'h0000_0000_A5A5A5A5);

    // below base address
    access(0, 1'b0, 1'b1, 32'd1020, 32'hCAFEF00D);
    access(0, 1'b1, 1'b0, 32'd1020, 32'd0);
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0);

    // reset during BUSY, then reset on the DONE entry edge
    access(0, 1'b0, 1'b1, 32'd1040, 32'h11111111);
    access(0, 1'b0, 1'b1, 32'd1044, 32'h22222222);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1040, 32'hFFFFFFFF);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("ready after busy reset", 64'(rdy1), 64'd1);
    check("readData after busy reset", rdat1, 64'd0);
    last1 = 64'd0;
    last2 = 64'd0;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1044, 32'hEEEEEEEE);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("ready after done-edge reset", 64'(rdy1), 64'd1);
    access(0, 1'b1, 1'b0, 32'd1040, 32'd0);
    check("aborted writes literal", rdat1, 64'h22222222_11111111);

    // small instance: beyond depth, then fill two blocks
    access(1, 1'b1, 1'b0, 32'd1088, 32'd0);
    access(1, 1'b0, 1'b1, 32'd1024, 32'h13579BDF);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h2468ACE0);
    access(1, 1'b0, 1'b1, 32'd1080, 32'h33334444);
    access(1, 1'b0, 1'b1, 32'd1084, 32'h55556666);
    access(1, 1'b0, 1'b1, 32'd1088, 32'h77777777);
    access(1, 1'b1, 1'b0, 32'd1084, 32'd0);

    // back-to-back reads with rdEn held
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'd1024, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 3 == 0) exp_q.push_back(model_block(1, 32'd1024));
      check($sformatf("b2b ready cycle %0d", k), 64'(rdy2), (k % 3 == 2) ? 64'd1 : 64'd0);
      if (k % 3 == 2) check($sformatf("b2b data cycle %0d", k), rdat2, exp_q.pop_front());
    end
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
